med_filter_frame_seq: RTL and testbench

- Frame sequencer and result monitor for `median_filter_proc`.
- On a `start` pulse it reads one grayscale frame from a synchronous pixel memory and drives the filter's `per_img_vsync/href/gray` stream with programmable blanking.
- It then watches the filter's `post_img_vsync/href` outputs and reports completion, pixel-count mismatch and timeout.
- It sits between the frame store and the filter and replaces hand-driven stimulus in system builds.

---
 rtl/med_filter_frame_seq_pkg.sv | 30 +++
 rtl/med_filter_frame_seq_post_monitor.sv | 41 ++++
 rtl/med_filter_frame_seq.sv | 147 ++++++++++++++
 tb/tb_med_filter_frame_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/med_filter_frame_seq_pkg.sv
// Shared types and sizing helpers for the median-filter frame sequencer.
package med_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VLEAD,
        HBLANK,
        ACTIVE,
        VTAIL,
        WAIT_POST
    } seq_state_t;

    function automatic int calc_aw(input int hdisp, input int vdisp);
        return $clog2(hdisp * vdisp);
    endfunction

    function automatic int frame_pixels(input int hdisp, input int vdisp);
        return hdisp * vdisp;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/med_filter_frame_seq_post_monitor.sv
// Watches the filter output stream: vsync falling-edge detect and
// a saturating count of href pixels seen while the sequencer is busy.
module med_post_monitor
    import med_seq_pkg::*;
#(
    parameter int AW        = 19,
    parameter int FRAME_PIX = 307200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic post_img_vsync,
    input  logic post_img_href,
    output logic post_fall,
    output logic count_ok
);

    localparam logic [AW:0] PIX_TARGET = (AW + 1)'(FRAME_PIX);

    logic        vsync_d;
    logic [AW:0] pix_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            pix_cnt <= '0;
        end else begin
            vsync_d <= post_img_vsync;
            if (clr)
                pix_cnt <= '0;
            else if (busy && post_img_href && (pix_cnt != '1))
                pix_cnt <= pix_cnt + (AW + 1)'(1);
        end
    end

    assign post_fall = vsync_d & ~post_img_vsync;
    assign count_ok  = (pix_cnt == PIX_TARGET);

endmodule

// File: rtl/med_filter_frame_seq.sv
// Reads one frame from pixel memory, drives it into the median filter with
// programmable blanking, then waits for the filter's frame to complete.
module med_filter_frame_seq
    import med_seq_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int V_LEAD    = 5,
    parameter int H_BLANK   = 10,
    parameter int V_TAIL    = 5,
    parameter int TIMEOUT   = 1 << 20,
    parameter int AW        = calc_aw(IMG_HDISP, IMG_VDISP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cnt_err,
    output logic          timeout_err,
    output logic [15:0]   frame_cnt,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          per_img_vsync,
    output logic          per_img_href,
    output logic [7:0]    per_img_gray,
    input  logic          post_img_vsync,
    input  logic          post_img_href
);

    localparam int PW = $clog2(max4(V_LEAD, H_BLANK, IMG_HDISP, V_TAIL) + 1);
    localparam int RW = $clog2(IMG_VDISP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t    state;
    logic [PW-1:0] phase;
    logic [RW-1:0] row;
    logic [TW-1:0] wait_cnt;
    logic [AW-1:0] addr;
    logic          start_ok;
    logic          vsync_int;
    logic          href_int;
    logic          post_fall;
    logic          count_ok;

    // A start coinciding with the done pulse belongs to the frame just finished.
    assign start_ok  = (state == IDLE) && start && !done;
    assign vsync_int = state inside {VLEAD, HBLANK, ACTIVE, VTAIL};
    assign href_int  = (state == ACTIVE);

    // Memory latency of one cycle lines read data up with the registered href.
    assign mem_rd_en    = href_int;
    assign mem_rd_addr  = addr;
    assign per_img_gray = per_img_href ? mem_rd_data : 8'd0;

    med_post_monitor #(
        .AW        (AW),
        .FRAME_PIX (frame_pixels(IMG_HDISP, IMG_VDISP))
    ) u_post_monitor (
        .clk            (clk),
        .rst            (rst),
        .clr            (start_ok),
        .busy           (busy),
        .post_img_vsync (post_img_vsync),
        .post_img_href  (post_img_href),
        .post_fall      (post_fall),
        .count_ok       (count_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= '0;
            row           <= '0;
            wait_cnt      <= '0;
            addr          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cnt_err       <= 1'b0;
            timeout_err   <= 1'b0;
            frame_cnt     <= '0;
            per_img_vsync <= 1'b0;
            per_img_href  <= 1'b0;
        end else begin
            done          <= 1'b0;
            per_img_vsync <= vsync_int;
            per_img_href  <= href_int;
            case (state)
                IDLE: if (start_ok) begin
                    state       <= VLEAD;
                    busy        <= 1'b1;
                    cnt_err     <= 1'b0;
                    timeout_err <= 1'b0;
                    addr        <= '0;
                    row         <= '0;
                    phase       <= '0;
                end
                VLEAD: if (phase == PW'(V_LEAD - 1)) begin
                    phase <= '0;
                    state <= HBLANK;
                end else begin
                    phase <= phase + PW'(1);
                end
                HBLANK: if (phase == PW'(H_BLANK - 1)) begin
                    phase <= '0;
                    state <= ACTIVE;
                end else begin
                    phase <= phase + PW'(1);
                end
                ACTIVE: begin
                    addr <= addr + AW'(1);
                    if (phase == PW'(IMG_HDISP - 1)) begin
                        phase <= '0;
                        row   <= row + RW'(1);
                        state <= (row == RW'(IMG_VDISP - 1)) ? VTAIL : HBLANK;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                VTAIL: if (phase == PW'(V_TAIL - 1)) begin
                    phase    <= '0;
                    wait_cnt <= '0;
                    state    <= WAIT_POST;
                end else begin
                    phase <= phase + PW'(1);
                end
                WAIT_POST: if (post_fall) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    if (!count_ok) cnt_err <= 1'b1;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    timeout_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_med_filter_frame_seq.sv
// Self-checking bench: frame table plus reset-abort and frame-counter wrap sequences.
module tb_med_filter_frame_seq;

    localparam int HD = 8, VD = 4, VL = 5, HB = 10, VT = 2, TO = 64;
    localparam int PIX       = HD * VD;
    localparam int AW        = $clog2(PIX);
    localparam int VS_LEN    = VL + VD * (HB + HD) + VT;   // 79
    localparam int BUSY_NORM = VS_LEN + 5;                 // vsync + 1 (reg) + 3 (filter) + 1 (edge)
    localparam int BUSY_HOLD = VS_LEN + TO;

    typedef enum logic [1:0] {M_NORMAL, M_DROP, M_HOLD} mode_t;
    typedef struct {
        mode_t mode;
        bit    inject;
        bit    exp_cnt_err;
        bit    exp_to_err;
        int    exp_busy;
        bit    fc_inc;
    } scen_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, cnt_err, timeout_err;
    logic [15:0]   frame_cnt;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data = 8'd0;
    logic          per_img_vsync, per_img_href;
    logic [7:0]    per_img_gray;
    logic          post_img_vsync, post_img_href;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  gq[$];
    logic [15:0] exp_fc = 16'd0;
    mode_t       model_mode = M_NORMAL;
    logic [2:0]  d_vs = 3'd0;
    logic [2:0]  d_hr = 3'd0;
    int          hr_idx = 0;
    scen_t       scen[5];

    med_filter_frame_seq #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .V_LEAD    (VL),
        .H_BLANK   (HB),
        .V_TAIL    (VT),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .cnt_err        (cnt_err),
        .timeout_err    (timeout_err),
        .frame_cnt      (frame_cnt),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .per_img_vsync  (per_img_vsync),
        .per_img_href   (per_img_href),
        .per_img_gray   (per_img_gray),
        .post_img_vsync (post_img_vsync),
        .post_img_href  (post_img_href)
    );

    always #5 clk = ~clk;

    // Pixel memory holding its own address; filter model delaying the stream 3 cycles.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 8'(mem_rd_addr);
        d_vs <= {d_vs[1:0], per_img_vsync};
        d_hr <= {d_hr[1:0], per_img_href};
        if (start) hr_idx <= 0;
        else if (d_hr[2]) hr_idx <= hr_idx + 1;
    end

    assign post_img_vsync = (model_mode == M_HOLD) ? 1'b1 : d_vs[2];
    assign post_img_href  = d_hr[2] && !(model_mode == M_DROP && hr_idx == 5);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input scen_t s, input string tag);
        int   vs_len = 0, href_n = 0, bursts = 0, busy_len = 0;
        int   vs_fall_c = -1, post_fall_c = -1, done_c = -1;
        logic prev_vs = 1'b0, prev_hr = 1'b0, prev_pvs;
        bit   injected = 0, gray_idle_bad = 0, idle_bad = 0;
        logic [7:0] exp_g;
        model_mode = s.mode;
        gq.delete();
        for (int i = 0; i < PIX; i++) gq.push_back(8'(i));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        prev_pvs = post_img_vsync;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start = 1'b0;
            if (busy) busy_len++;
            if (per_img_vsync) vs_len++;
            if (prev_vs && !per_img_vsync && vs_fall_c < 0) vs_fall_c = cyc;
            if (per_img_href) begin
                href_n++;
                if (!prev_hr) bursts++;
                if (gq.size() == 0) begin
                    check({tag, " extra pixel"}, 32'd1, 32'd0);
                end else begin
                    exp_g = gq.pop_front();
                    check({tag, " gray"}, 32'(per_img_gray), 32'(exp_g));
                end
                if (s.inject && !injected) begin
                    start    = 1'b1;
                    injected = 1;
                end
            end else if (per_img_gray != 8'd0) begin
                gray_idle_bad = 1;
            end
            if (prev_pvs && !post_img_vsync) post_fall_c = cyc;
            prev_vs  = per_img_vsync;
            prev_hr  = per_img_href;
            prev_pvs = post_img_vsync;
            if (done) begin
                done_c = cyc;
                if (s.inject) start = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (done_c < 0) check({tag, " done seen"}, 32'd0, 32'd1);
        if (s.fc_inc) exp_fc = exp_fc + 16'd1;
        check({tag, " cnt_err"}, 32'(cnt_err), 32'(s.exp_cnt_err));
        check({tag, " timeout_err"}, 32'(timeout_err), 32'(s.exp_to_err));
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
        check({tag, " vsync len"}, vs_len, VS_LEN);
        check({tag, " href pixels"}, href_n, PIX);
        check({tag, " href bursts"}, bursts, VD);
        check({tag, " busy len"}, busy_len, s.exp_busy);
        check({tag, " pixels left"}, gq.size(), 0);
        check({tag, " gray outside href"}, 32'(gray_idle_bad), 32'd0);
        if (s.mode == M_HOLD) check({tag, " done vs timeout"}, done_c, vs_fall_c + TO - 1);
        else                  check({tag, " done vs post fall"}, done_c, post_fall_c + 1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy || done || per_img_vsync) idle_bad = 1;
            @(negedge clk);
        end
        check({tag, " idle after done"}, 32'(idle_bad), 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  href_n;
        bit  found;
        scen_t norm;
        scen[0] = '{mode: M_NORMAL, inject: 0, exp_cnt_err: 0, exp_to_err: 0, exp_busy: BUSY_NORM, fc_inc: 1};
        scen[1] = '{mode: M_DROP,   inject: 0, exp_cnt_err: 1, exp_to_err: 0, exp_busy: BUSY_NORM, fc_inc: 1};
        scen[2] = '{mode: M_NORMAL, inject: 0, exp_cnt_err: 0, exp_to_err: 0, exp_busy: BUSY_NORM, fc_inc: 1};
        scen[3] = '{mode: M_HOLD,   inject: 0, exp_cnt_err: 0, exp_to_err: 1, exp_busy: BUSY_HOLD, fc_inc: 0};
        scen[4] = '{mode: M_NORMAL, inject: 1, exp_cnt_err: 0, exp_to_err: 0, exp_busy: BUSY_NORM, fc_inc: 1};
        norm = scen[0];

        #1;
        check("reset outputs",
              32'({per_img_vsync, per_img_href, per_img_gray, busy, done, cnt_err,
                   timeout_err, frame_cnt, mem_rd_en, mem_rd_addr}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(scen[i], $sformatf("frame%0d", i));

        // Reset while row 2 is being streamed.
        model_mode = M_NORMAL;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        href_n = 0;
        found  = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (per_img_href) begin
                href_n++;
                if (href_n == 2 * HD + 5) begin
                    found = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        check("reached row 2", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("mid-frame reset outputs",
              32'({per_img_vsync, per_img_href, per_img_gray, busy, done, cnt_err,
                   timeout_err, frame_cnt, mem_rd_en, mem_rd_addr}), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        exp_fc = 16'd0;
        repeat (10) @(negedge clk);
        run_frame(norm, "after reset");

        // Frame counter wrap.
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        #1;
        check("frame_cnt preload", 32'(frame_cnt), 32'h0000FFFF);
        exp_fc = 16'hFFFF;
        run_frame(norm, "wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
